// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, 8N1 LSB first.
// Emits a one-cycle strobe per good frame and a one-cycle pulse on a bad stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT     = 16,
  parameter int UART_DATA_LENGTH = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        rx_i,
  output logic [UART_DATA_LENGTH-1:0] data_o,
  output logic                        data_valid_strb_o,
  output logic                        frame_error_o,
  output logic                        busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (UART_DATA_LENGTH > 1) ?
                      $clog2(UART_DATA_LENGTH) : 1;

  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(UART_DATA_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [BW-1:0]               idx_q, idx_d;
  logic [UART_DATA_LENGTH-1:0] shift_q, shift_d;
  logic [UART_DATA_LENGTH-1:0] data_q, data_d;
  logic                        strb_q, strb_d;
  logic                        ferr_q, ferr_d;
  logic                        sync1_q, rx_s_q, rx_d_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      strb_q  <= 1'b0;
      ferr_q  <= 1'b0;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      ferr_q  <= ferr_d;
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  // Counter free-runs outside IDLE; samples are taken at fixed counts only.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    strb_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_d_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          if (rx_s_q) begin
            data_d = shift_q;
            strb_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
  end

  assign data_o            = data_q;
  assign data_valid_strb_o = strb_q;
  assign frame_error_o     = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are pushed as expected events,
// a negedge monitor pops them when the DUT pulses.
module tb_uart_rx;

  localparam int CPB = 4;
  localparam int LEN = 8;
  localparam int LAT = 2 + CPB/2 + (LEN+1)*CPB + 1;

  logic           clk = 1'b0;
  logic           reset_i;
  logic           rx_i;
  logic [LEN-1:0] data_o;
  logic           strb;
  logic           ferr;
  logic           busy;

  typedef struct {
    bit             err;
    logic [LEN-1:0] data;
    time            t;
  } exp_t;

  exp_t           sb[$];
  exp_t           me;
  int             errors = 0;
  int             checks = 0;
  logic [LEN-1:0] last_good = '0;
  bit             prev_pulse = 1'b0;
  bit             rst_prev = 1'b0;
  int             lat;

  uart_rx #(
    .CLKS_PER_BIT    (CPB),
    .UART_DATA_LENGTH(LEN)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .rx_i             (rx_i),
    .data_o           (data_o),
    .data_valid_strb_o(strb),
    .frame_error_o    (ferr),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_i && rst_prev)
      check("reset_outputs", {data_o, strb, ferr, busy}, '0);
    if (strb || ferr) begin
      check("pulse_exclusive", strb & ferr, 0);
      check("pulse_single_cycle", prev_pulse, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: strb=%0b ferr=%0b expected none",
                 strb, ferr);
      end else begin
        me = sb.pop_front();
        check("pulse_kind_ferr", ferr, me.err);
        lat = int'(($time - me.t) / 10);
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
          errors++;
          $display("FAIL latency: got %0d expected %0d+-1", lat, LAT);
        end
        if (!me.err) begin
          check("data", data_o, me.data);
          last_good = me.data;
        end else begin
          check("data_hold", data_o, last_good);
        end
      end
    end
    prev_pulse = strb || ferr;
    rst_prev   = reset_i;
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [LEN-1:0] d, input bit stop);
    exp_t e;
    e.err  = !stop;
    e.data = d;
    e.t    = $time;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < LEN; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [LEN-1:0] a81;
    logic [LEN-1:0] d;
    bit             stop;
    int             gap;

    reset_i = 1'b1;
    rx_i    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_strb", strb, 0);
    check("rst_ferr", ferr, 0);
    check("rst_data", data_o, 0);
    reset_i = 1'b0;
    idle(2*CPB);

    send_frame(8'hA5, 1'b1);
    idle(3*CPB);
    check("a5_data", data_o, 8'hA5);

    send_frame(8'h3C, 1'b1);
    send_frame(8'hF0, 1'b1);
    idle(3*CPB);

    send_frame(8'h55, 1'b0);
    idle(3*CPB);
    check("data_after_ferr", data_o, 8'hF0);

    rx_i = 1'b0;
    @(negedge clk);
    rx_i = 1'b1;
    repeat (CPB) @(negedge clk);
    check("glitch_busy", busy, 0);
    idle(2*CPB);

    a81  = 8'h81;
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) drive_bit(a81[i]);
    rx_i = a81[3];
    repeat (2) @(negedge clk);
    reset_i   = 1'b1;
    last_good = '0;
    rx_i      = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_outputs", {data_o, strb, ferr, busy}, 0);
    reset_i = 1'b0;
    idle(2*CPB);
    send_frame(8'h7E, 1'b1);
    idle(3*CPB);
    check("after_abort_data", data_o, 8'h7E);

    send_frame(8'h55, 1'b0);
    rx_i = 1'b0;
    repeat (20*CPB) @(negedge clk);
    check("break_busy", busy, 0);
    idle(2*CPB);

    for (int n = 0; n < 40; n++) begin
      d    = LEN'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop);
      gap  = stop ? int'($urandom_range(0, 6))
                  : int'($urandom_range(CPB, 2*CPB));
      idle(gap);
    end

    idle(60);
    check("scoreboard_empty", sb.size(), 0);
    check("final_data", data_o, last_good);
    check("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk_i cycles per UART bit period; legal values are 4 or greater, and even.
REQ-002 Parameter UART_DATA_LENGTH, default 8, data bits per frame.
REQ-003 Port clk_i  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset_i  input  1  synchronous, active-high reset.
REQ-005 Port rx_i  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-006 Port data_o  output  UART_DATA_LENGTH  last correctly framed byte; held until the next good frame.
REQ-007 Port data_valid_strb_o  output  1  one-cycle pulse: data_o updated this cycle; feeds the programmer's data_valid_strb_i.
REQ-008 Port frame_error_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 Port busy_o  output  1  high in every state except IDLE.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer (reset value 1); all logic below uses the synchronized bit rx_s and its one-cycle-delayed copy rx_d.
REQ-011 FSM states: IDLE, START, DATA, STOP; 2-bit encoding; illegal encodings return to IDLE.
REQ-012 IDLE: on rx_d=1 and rx_s=0 (falling edge), go to START and clear the baud counter; a line held low (break) SHALL NOT retrigger.
REQ-013 Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0; width is clog2(CLKS_PER_BIT).
REQ-014 START: sample rx_s at counter = CLKS_PER_BIT/2-1 (mid-bit). If 0, go to DATA, clear the counter and bit index. If 1 (glitch), return to IDLE with no output pulse.
REQ-015 DATA: sample rx_s at counter = CLKS_PER_BIT-1 into shift register bit [bit index], LSB first, then increment bit index; after bit UART_DATA_LENGTH-1, go to STOP.
REQ-016 STOP: sample rx_s at counter = CLKS_PER_BIT-1. If 1, load data_o from the shift register and pulse data_valid_strb_o in the next cycle. If 0, pulse frame_error_o in the next cycle and leave data_o unchanged. Both cases then return to IDLE.
REQ-017 data_valid_strb_o and frame_error_o SHALL be mutually exclusive and never high for two consecutive cycles.
REQ-018 Return to IDLE occurs at mid-stop-bit, so a start edge 0.5 bit later (back-to-back frames) SHALL be detected.
REQ-019 Latency: the strobe rises 2 + CLKS_PER_BIT/2 + (UART_DATA_LENGTH+1)*CLKS_PER_BIT + 1 cycles after the rx_i falling edge, ±1 cycle for synchronizer phase.
REQ-020 rx_i activity while busy_o=1 SHALL NOT alter the sampling schedule; there is no resynchronization mid-frame.
REQ-021 The shift register contents SHALL NOT appear on data_o until a valid stop bit is sampled.

Reset
REQ-022 While reset_i=1 at a clock edge, the block SHALL set: state=IDLE, counter=0, bit index=0, shift register=0, data_o=0, data_valid_strb_o=0, frame_error_o=0, busy_o=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse; the next complete frame after deassertion SHALL be received correctly.

Verification (CLKS_PER_BIT=4, UART_DATA_LENGTH=8)
REQ-024 Send 0xA5 with a valid stop bit -> data_o=0xA5; data_valid_strb_o high for exactly 1 cycle; frame_error_o stays 0.
REQ-025 Send 0x3C, then 0xF0 back-to-back with 1 stop bit and no idle gap -> two strobes with data_o=0x3C, then 0xF0.
REQ-026 Send 0x55 with the stop bit low -> frame_error_o pulses for 1 cycle; no strobe; data_o retains its previous value (0xF0 after the REQ-025 sequence).
REQ-027 Drive rx_i low for 1 cycle (shorter than half a bit) -> no pulses; busy_o returns to 0 within CLKS_PER_BIT cycles.
REQ-028 Assert reset_i during data bit 3 of frame 0x81, then send 0x7E -> all outputs 0 during reset; one strobe follows with data_o=0x7E.
REQ-029 Hold rx_i low for 20 bit times after a frame error -> exactly one frame_error_o pulse, and no further activity until rx_i returns high.
